// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order-retire reorder buffer between rename/dispatch and architectural
//   commit. Up to DISPATCH_WIDTH entries are allocated per cycle at the tail.
//   COMPLETE_WIDTH writeback ports mark entries done. Up to COMMIT_WIDTH
//   consecutive done entries retire per cycle from the head. A flush discards
//   everything in flight.
//   Head and tail carry one extra wrap bit, so a full ring and an empty ring
//   are told apart without a separate occupancy counter.
module reorder_buffer #(
    parameter int  DEPTH          = 32,
    parameter int  DISPATCH_WIDTH = 2,
    parameter int  COMMIT_WIDTH   = 2,
    parameter int  COMPLETE_WIDTH = 2,
    parameter int  PHYS_W         = 8,
    parameter int  ARCH_W         = 5,
    localparam int TAG_W          = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [DISPATCH_WIDTH-1:0]          disp_valid,
    input  logic [DISPATCH_WIDTH*PHYS_W-1:0]   disp_phys_rd,
    input  logic [DISPATCH_WIDTH*ARCH_W-1:0]   disp_arch_rd,
    input  logic [DISPATCH_WIDTH-1:0]          disp_rd_en,
    output logic [DISPATCH_WIDTH*TAG_W-1:0]    disp_tag,
    output logic                               full,
    output logic                               empty,
    output logic [TAG_W:0]                     entry_count,
    input  logic [COMPLETE_WIDTH-1:0]          cmpl_valid,
    input  logic [COMPLETE_WIDTH*TAG_W-1:0]    cmpl_tag,
    output logic [COMMIT_WIDTH-1:0]            commit_valid,
    output logic [COMMIT_WIDTH*TAG_W-1:0]      commit_tag,
    output logic [COMMIT_WIDTH*PHYS_W-1:0]     commit_phys_rd,
    output logic [COMMIT_WIDTH*ARCH_W-1:0]     commit_arch_rd,
    output logic [COMMIT_WIDTH-1:0]            commit_rd_en
);

    localparam int               PTR_W      = TAG_W + 1;
    // Full means fewer free slots than one complete dispatch group needs.
    localparam logic [PTR_W-1:0] FULL_LIMIT = PTR_W'(DEPTH - DISPATCH_WIDTH);

    // Number of active dispatch lanes.
    function automatic logic [PTR_W-1:0] count_disp(input logic [DISPATCH_WIDTH-1:0] v);
        logic [PTR_W-1:0] n;
        n = {PTR_W{1'b0}};
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            n = n + PTR_W'(v[i]);
        end
        return n;
    endfunction

    // Number of retiring commit lanes.
    function automatic logic [PTR_W-1:0] count_commit(input logic [COMMIT_WIDTH-1:0] v);
        logic [PTR_W-1:0] n;
        n = {PTR_W{1'b0}};
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            n = n + PTR_W'(v[i]);
        end
        return n;
    endfunction

    // Per-entry state.
    logic [DEPTH-1:0]       valid_r;
    logic [DEPTH-1:0]       done_r;
    logic [DEPTH-1:0]       rd_en_r;
    logic [PHYS_W-1:0]      phys_r [DEPTH];
    logic [ARCH_W-1:0]      arch_r [DEPTH];
    logic [PTR_W-1:0]       head_r;
    logic [PTR_W-1:0]       tail_r;

    // Derived signals.
    logic [PTR_W-1:0]        count_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    disp_ok_s;
    logic [PTR_W-1:0]        n_disp_s;
    logic [PTR_W-1:0]        n_commit_s;
    logic [COMMIT_WIDTH-1:0] commit_valid_s;
    logic [TAG_W-1:0]        disp_idx_s   [DISPATCH_WIDTH];
    logic [TAG_W-1:0]        commit_idx_s [COMMIT_WIDTH];
    logic [TAG_W-1:0]        cmpl_idx_s   [COMPLETE_WIDTH];

    // Slot addresses: dispatch lanes follow the tail, commit lanes follow the head.
    for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_disp
        assign disp_idx_s[gi]               = tail_r[TAG_W-1:0] + TAG_W'(gi);
        assign disp_tag[gi*TAG_W +: TAG_W] = disp_idx_s[gi];
    end

    for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_commit
        assign commit_idx_s[gi]                  = head_r[TAG_W-1:0] + TAG_W'(gi);
        assign commit_tag[gi*TAG_W +: TAG_W]     = commit_idx_s[gi];
        assign commit_phys_rd[gi*PHYS_W +: PHYS_W] = phys_r[commit_idx_s[gi]];
        assign commit_arch_rd[gi*ARCH_W +: ARCH_W] = arch_r[commit_idx_s[gi]];
        assign commit_rd_en[gi]                  = rd_en_r[commit_idx_s[gi]];
    end

    for (genvar gj = 0; gj < COMPLETE_WIDTH; gj++) begin : g_cmpl
        assign cmpl_idx_s[gj] = cmpl_tag[gj*TAG_W +: TAG_W];
    end

    // Occupancy flags and dispatch admission.
    // full looks only at the registered count, so a same-cycle commit gives no credit.
    always_comb begin
        count_s   = tail_r - head_r;
        full_s    = (count_s > FULL_LIMIT);
        empty_s   = (count_s == {PTR_W{1'b0}});
        disp_ok_s = !full_s && !flush;
        if (disp_ok_s) begin
            n_disp_s = count_disp(disp_valid);
        end else begin
            n_disp_s = {PTR_W{1'b0}};
        end
    end

    // Retire chain: lane i fires only if entries head..head+i are all valid and done.
    always_comb begin : commit_chain
        logic chain;
        chain          = 1'b1;
        commit_valid_s = {COMMIT_WIDTH{1'b0}};
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            chain             = chain & valid_r[commit_idx_s[i]] & done_r[commit_idx_s[i]];
            commit_valid_s[i] = chain & ~flush;
        end
        n_commit_s = count_commit(commit_valid_s);
    end

    assign full         = full_s;
    assign empty        = empty_s;
    assign entry_count  = count_s;
    assign commit_valid = commit_valid_s;

    // Entry lifecycle and pointers.
    // Reset beats flush; otherwise completions, retirements and allocations land together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            valid_r <= {DEPTH{1'b0}};
            done_r  <= {DEPTH{1'b0}};
        end else if (flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            valid_r <= {DEPTH{1'b0}};
            done_r  <= {DEPTH{1'b0}};
        end else begin
            // A completion aimed at an unallocated slot is dropped.
            for (int j = 0; j < COMPLETE_WIDTH; j++) begin
                if (cmpl_valid[j] && valid_r[cmpl_idx_s[j]]) begin
                    done_r[cmpl_idx_s[j]] <= 1'b1;
                end
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (commit_valid_s[i]) begin
                    valid_r[commit_idx_s[i]] <= 1'b0;
                    done_r[commit_idx_s[i]]  <= 1'b0;
                end
            end
            // Admission guarantees the tail slots are free, so they never alias live entries.
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (disp_ok_s && disp_valid[i]) begin
                    valid_r[disp_idx_s[i]] <= 1'b1;
                    done_r[disp_idx_s[i]]  <= 1'b0;
                end
            end
            head_r <= head_r + n_commit_s;
            tail_r <= tail_r + n_disp_s;
        end
    end

    // Payload capture on allocation.
    // The payload is only observed while its entry is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (rst && disp_ok_s && disp_valid[i]) begin
                phys_r[disp_idx_s[i]]  <= disp_phys_rd[i*PHYS_W +: PHYS_W];
                arch_r[disp_idx_s[i]]  <= disp_arch_rd[i*ARCH_W +: ARCH_W];
                rd_en_r[disp_idx_s[i]] <= disp_rd_en[i];
            end
        end
    end

    // Dispatch lanes must be packed from lane 0: v & (v + 1) is zero only for such masks.
    logic [DISPATCH_WIDTH-1:0] disp_valid_inc_s;
    assign disp_valid_inc_s = disp_valid + DISPATCH_WIDTH'(1);

    a_disp_contiguous: assert property (@(posedge clk) disable iff (!rst)
        ((disp_valid & disp_valid_inc_s) == {DISPATCH_WIDTH{1'b0}}));

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer.
// The reference model is a queue of in-flight instructions in program order.
// Each element holds its tag and a done flag. At every rising edge the model
// retires the leading done entries, applies completions and appends
// dispatches. A negedge process compares every DUT output against it.
// Directed sequences pin a few literal values.
module tb_reorder_buffer;
    localparam int DEPTH = 32;
    localparam int DW    = 2;
    localparam int CW    = 2;
    localparam int XW    = 2;
    localparam int PW    = 8;
    localparam int AW    = 5;
    localparam int TW    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [DW-1:0]     disp_valid;
    logic [DW*PW-1:0]  disp_phys_rd;
    logic [DW*AW-1:0]  disp_arch_rd;
    logic [DW-1:0]     disp_rd_en;
    logic [DW*TW-1:0]  disp_tag;
    logic              full;
    logic              empty;
    logic [TW:0]       entry_count;
    logic [XW-1:0]     cmpl_valid;
    logic [XW*TW-1:0]  cmpl_tag;
    logic [CW-1:0]     commit_valid;
    logic [CW*TW-1:0]  commit_tag;
    logic [CW*PW-1:0]  commit_phys_rd;
    logic [CW*AW-1:0]  commit_arch_rd;
    logic [CW-1:0]     commit_rd_en;

    reorder_buffer #(
        .DEPTH(DEPTH), .DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW), .COMPLETE_WIDTH(XW),
        .PHYS_W(PW), .ARCH_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_phys_rd(disp_phys_rd), .disp_arch_rd(disp_arch_rd),
        .disp_rd_en(disp_rd_en), .disp_tag(disp_tag), .full(full), .empty(empty),
        .entry_count(entry_count), .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_phys_rd(commit_phys_rd),
        .commit_arch_rd(commit_arch_rd), .commit_rd_en(commit_rd_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic [PW-1:0] phys;
        logic [AW-1:0] arch;
        logic          rd_en;
        bit            done;
    } ent_t;

    ent_t q[$];
    int   next_tag   = 0;
    bit   model_ok   = 1'b0;
    int   n_checks   = 0;
    int   n_fail     = 0;
    bit   rec_en     = 1'b0;
    int   rec[$];
    int   n_win_disp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Entries retiring this cycle: leading done entries, at most CW, none during a flush.
    function automatic int exp_commits();
        int k = 0;
        if (flush) return 0;
        while (k < CW && k < q.size() && q[k].done) k++;
        return k;
    endfunction

    function automatic bit exp_full();
        return (DEPTH - q.size()) < DW;
    endfunction

    int            m_k;
    bit            m_full;
    logic [TW-1:0] m_tag;
    ent_t          m_e;
    // Reference model: advance the in-flight queue at each rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            next_tag = 0;
            model_ok = 1'b1;
        end else if (flush) begin
            q.delete();
            next_tag = 0;
        end else begin
            m_k    = exp_commits();
            m_full = exp_full();
            for (int j = 0; j < XW; j++) begin
                if (cmpl_valid[j]) begin
                    m_tag = cmpl_tag[j*TW +: TW];
                    foreach (q[e]) begin
                        if (q[e].tag == int'(m_tag)) begin
                            m_e      = q[e];
                            m_e.done = 1'b1;
                            q[e]     = m_e;
                        end
                    end
                end
            end
            for (int i = 0; i < m_k; i++) void'(q.pop_front());
            if (!m_full) begin
                for (int i = 0; i < DW; i++) begin
                    if (disp_valid[i]) begin
                        m_e.tag   = next_tag;
                        m_e.phys  = disp_phys_rd[i*PW +: PW];
                        m_e.arch  = disp_arch_rd[i*AW +: AW];
                        m_e.rd_en = disp_rd_en[i];
                        m_e.done  = 1'b0;
                        q.push_back(m_e);
                        next_tag = (next_tag + 1) % DEPTH;
                        if (rec_en) n_win_disp++;
                    end
                end
            end
        end
    end

    int            c_k;
    logic [CW-1:0] c_cv;
    // Compare process: check every DUT output against the model just before each edge.
    always @(negedge clk) begin
        if (model_ok && rst) begin
            c_k  = exp_commits();
            c_cv = '0;
            for (int i = 0; i < c_k; i++) c_cv[i] = 1'b1;
            chk("entry_count", 64'(entry_count), 64'(q.size()));
            chk("full", 64'(full), 64'(exp_full()));
            chk("empty", 64'(empty), 64'(q.size() == 0));
            for (int i = 0; i < DW; i++)
                chk("disp_tag", 64'(disp_tag[i*TW +: TW]), 64'((next_tag + i) % DEPTH));
            chk("commit_valid", 64'(commit_valid), 64'(c_cv));
            for (int i = 0; i < c_k; i++) begin
                chk("commit_tag", 64'(commit_tag[i*TW +: TW]), 64'(q[i].tag));
                chk("commit_phys_rd", 64'(commit_phys_rd[i*PW +: PW]), 64'(q[i].phys));
                chk("commit_arch_rd", 64'(commit_arch_rd[i*AW +: AW]), 64'(q[i].arch));
                chk("commit_rd_en", 64'(commit_rd_en[i]), 64'(q[i].rd_en));
            end
            if (rec_en) begin
                for (int i = 0; i < CW; i++)
                    if (commit_valid[i]) rec.push_back(int'(commit_tag[i*TW +: TW]));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        flush      = 1'b0;
        disp_valid = 2'b00;
        cmpl_valid = 2'b00;
    endtask

    task automatic rand_payload();
        disp_phys_rd = 16'($urandom);
        disp_arch_rd = 10'($urandom);
        disp_rd_en   = 2'($urandom);
    endtask

    // Complete the two oldest in-flight entries.
    task automatic complete_oldest();
        cmpl_valid = 2'b00;
        for (int j = 0; j < XW; j++) begin
            if (j < q.size()) begin
                cmpl_valid[j]        = 1'b1;
                cmpl_tag[j*TW +: TW] = 5'(q[j].tag);
            end
        end
    endtask

    task automatic rand_cycle(input bit allow_flush);
        int r;
        int hi;
        r = $urandom_range(0, 9);
        disp_valid = (r < 6) ? 2'b11 : ((r < 8) ? 2'b01 : 2'b00);
        rand_payload();
        cmpl_valid = 2'b00;
        cmpl_tag   = 10'($urandom);
        for (int j = 0; j < XW; j++) begin
            r = $urandom_range(0, 9);
            if (r < 8 && q.size() > 0) begin
                cmpl_valid[j] = 1'b1;
                hi = (r < 5) ? ((q.size() > 4) ? 3 : q.size() - 1) : q.size() - 1;
                cmpl_tag[j*TW +: TW] = 5'(q[$urandom_range(0, hi)].tag);
            end else if (r == 8) begin
                cmpl_valid[j] = 1'b1;
            end
        end
        flush = allow_flush && ($urandom_range(0, 39) == 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            complete_oldest();
            next();
            n++;
        end
        idle();
        mid();
        chk("drain_empty", 64'(empty), 64'(1'b1));
    endtask

    int brk;
    bit wrap;
    initial begin
        rst = 1'b0;
        idle();
        disp_phys_rd = '0;
        disp_arch_rd = '0;
        disp_rd_en   = '0;
        cmpl_tag     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        mid();
        chk("reset_full", 64'(full), 64'(1'b0));
        chk("reset_empty", 64'(empty), 64'(1'b1));
        chk("reset_count", 64'(entry_count), 64'(6'd0));
        chk("reset_commit_valid", 64'(commit_valid), 64'(2'b00));

        // Two-lane dispatch: first tags are 0 and 1.
        next();
        disp_valid   = 2'b11;
        disp_phys_rd = {8'h22, 8'h21};
        disp_arch_rd = {5'd4, 5'd3};
        disp_rd_en   = 2'b11;
        mid();
        chk("t1_disp_tag", 64'(disp_tag), 64'({5'd1, 5'd0}));
        next();
        idle();
        mid();
        chk("t1_count", 64'(entry_count), 64'(6'd2));
        chk("t1_empty", 64'(empty), 64'(1'b0));
        chk("t1_commit_valid", 64'(commit_valid), 64'(2'b00));

        // Younger completes first: nothing retires until tag 0 is done.
        next();
        cmpl_valid = 2'b01;
        cmpl_tag   = {5'd0, 5'd1};
        next();
        idle();
        mid();
        chk("t2_no_commit", 64'(commit_valid), 64'(2'b00));
        next();
        cmpl_valid = 2'b01;
        cmpl_tag   = {5'd0, 5'd0};
        next();
        idle();
        mid();
        chk("t2_commit_valid", 64'(commit_valid), 64'(2'b11));
        chk("t2_commit_tag", 64'(commit_tag), 64'({5'd1, 5'd0}));
        chk("t2_commit_phys", 64'(commit_phys_rd), 64'({8'h22, 8'h21}));
        chk("t2_commit_arch", 64'(commit_arch_rd), 64'({5'd4, 5'd3}));
        next();
        mid();
        chk("t2_empty", 64'(empty), 64'(1'b1));

        // Fill to 31 entries: one free slot is less than a dispatch group, so full.
        next();
        for (int c = 0; c < 16; c++) begin
            disp_valid = (c == 15) ? 2'b01 : 2'b11;
            rand_payload();
            next();
        end
        idle();
        mid();
        chk("t3_full", 64'(full), 64'(1'b1));
        chk("t3_count", 64'(entry_count), 64'(6'd31));
        next();
        disp_valid = 2'b11;
        rand_payload();
        next();
        idle();
        mid();
        chk("t3_ignored_count", 64'(entry_count), 64'(6'd31));

        // Count 31: retire 2 while full, so dispatch is still refused and count drops to 29.
        next();
        complete_oldest();
        next();
        idle();
        disp_valid = 2'b11;
        rand_payload();
        mid();
        chk("t6a_full", 64'(full), 64'(1'b1));
        chk("t6a_commit", 64'(commit_valid), 64'(2'b11));
        next();
        idle();
        mid();
        chk("t6a_count", 64'(entry_count), 64'(6'd29));

        // Count 30: two free slots are enough, so dispatch 2 + commit 2 keeps it at 30.
        next();
        disp_valid = 2'b01;
        rand_payload();
        complete_oldest();
        next();
        idle();
        disp_valid = 2'b11;
        rand_payload();
        mid();
        chk("t6b_count_before", 64'(entry_count), 64'(6'd30));
        chk("t6b_full", 64'(full), 64'(1'b0));
        chk("t6b_commit", 64'(commit_valid), 64'(2'b11));
        next();
        idle();
        mid();
        chk("t6b_count_after", 64'(entry_count), 64'(6'd30));
        chk("t6b_full_after", 64'(full), 64'(1'b0));
        next();
        drain();

        // Random traffic across the pointer wrap: retirement must be one unbroken tag sequence.
        next();
        rec.delete();
        n_win_disp = 0;
        rec_en     = 1'b1;
        for (int c = 0; c < 80; c++) begin
            rand_cycle(1'b0);
            next();
        end
        idle();
        drain();
        rec_en = 1'b0;
        brk  = 0;
        wrap = 1'b0;
        for (int i = 0; i + 1 < rec.size(); i++) begin
            if (rec[i+1] != (rec[i] + 1) % DEPTH) brk++;
            if (rec[i] == DEPTH - 1 && rec[i+1] == 0) wrap = 1'b1;
        end
        chk("t4_retired_all", 64'(rec.size()), 64'(n_win_disp));
        chk("t4_order_breaks", 64'(brk), 64'(0));
        chk("t4_wrap_31_0", 64'(wrap), 64'(1'b1));

        // Flush with 10 in flight and the 4 oldest done: no retirement that cycle, then empty.
        next();
        for (int c = 0; c < 5; c++) begin
            disp_valid = 2'b11;
            rand_payload();
            next();
        end
        idle();
        cmpl_valid = 2'b11;
        cmpl_tag   = {5'(q[3].tag), 5'(q[2].tag)};
        next();
        cmpl_tag   = {5'(q[1].tag), 5'(q[0].tag)};
        next();
        idle();
        flush      = 1'b1;
        disp_valid = 2'b11;
        rand_payload();
        cmpl_valid = 2'b11;
        cmpl_tag   = {5'(q[5].tag), 5'(q[4].tag)};
        mid();
        chk("t5_count_before", 64'(entry_count), 64'(6'd10));
        chk("t5_commit_forced_off", 64'(commit_valid), 64'(2'b00));
        next();
        idle();
        mid();
        chk("t5_count_after", 64'(entry_count), 64'(6'd0));
        chk("t5_disp_tag", 64'(disp_tag), 64'({5'd1, 5'd0}));

        // Reset mid-operation, with flush and dispatch also asserted.
        next();
        for (int c = 0; c < 4; c++) begin
            rand_cycle(1'b0);
            next();
        end
        idle();
        rst        = 1'b0;
        flush      = 1'b1;
        disp_valid = 2'b11;
        next();
        rst = 1'b1;
        idle();
        mid();
        chk("t7_count", 64'(entry_count), 64'(6'd0));
        chk("t7_empty", 64'(empty), 64'(1'b1));
        chk("t7_disp_tag", 64'(disp_tag), 64'({5'd1, 5'd0}));

        // Long random run with occasional flushes.
        next();
        for (int c = 0; c < 400; c++) begin
            rand_cycle(1'b1);
            next();
        end
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
